// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM:
// state encoding, opcodes, ALU operation classes and the control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11,
    ST_TRAP    = 4'd12
  } mc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Full control word produced by the state decoder; alu_op is the narrow
  // class code and is zero-extended at the top level.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic       branch_ne;
    logic       pc_write;
    logic       trap;
  } ctrl_t;

  // States that hold for mem_ready before advancing.
  function automatic logic waits_on_memory(mc_state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_out_dec.sv
// Combinational state-to-control-word decode with mem_ready gating of the
// memory-completion strobes and the reset-time strobe squash.
module mc_out_dec
  import mips_ctrl_pkg::*;
#(
  parameter int BNE_EN = 1
) (
  input  mc_state_t  state,
  input  logic [5:0] op,
  input  logic       ready,
  input  logic       reset,
  output ctrl_t      ctrl
);

  ctrl_t word;

  always_comb begin
    word = '0;
    case (state)
      ST_FETCH: begin
        word.mem_req   = 1'b1;
        word.alu_src_b = 2'b01;
        word.alu_op    = ALUOP_ADD;
        word.ir_write  = ready;
        word.pc_write  = ready;
      end
      ST_DECODE: begin
        word.alu_src_b = 2'b11;
        word.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        word.alu_src_a = 1'b1;
        word.alu_src_b = 2'b10;
        word.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        word.mem_req = 1'b1;
        word.iord    = 1'b1;
      end
      ST_MEMWB: begin
        word.reg_write  = 1'b1;
        word.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        word.mem_req   = 1'b1;
        word.iord      = 1'b1;
        word.mem_write = ready;
      end
      ST_EXECUTE: begin
        word.alu_src_a = 1'b1;
        word.alu_src_b = 2'b00;
        word.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        word.reg_write = 1'b1;
        word.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        // op is still the branch opcode here: IR is stable to instruction end.
        word.alu_src_a = 1'b1;
        word.alu_src_b = 2'b00;
        word.alu_op    = ALUOP_SUB;
        word.pc_src    = 2'b01;
        word.branch    = (op == OP_BEQ);
        word.branch_ne = (BNE_EN != 0) && (op == OP_BNE);
      end
      ST_ADDIWB: begin
        word.reg_write = 1'b1;
      end
      ST_JUMP: begin
        word.pc_src   = 2'b10;
        word.pc_write = 1'b1;
      end
      ST_TRAP: begin
        word.trap = 1'b1;
      end
      default: word = '0;
    endcase
  end

  // During reset every strobe is low and the mux selects show FETCH values.
  always_comb begin
    ctrl = word;
    if (reset) begin
      ctrl           = '0;
      ctrl.alu_src_b = 2'b01;
      ctrl.alu_op    = ALUOP_ADD;
      ctrl.trap      = word.trap;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: state register and next-state logic; the
// control word comes from mc_out_dec.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W       = 2,
  parameter int MEM_HANDSHAKE = 1,
  parameter int BNE_EN        = 1,
  parameter int TRAP_ILLEGAL  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               branch,
  output logic               branch_ne,
  output logic               pc_write,
  output logic               trap
);

  mc_state_t state_reg, state_next, illegal_next;
  logic      ready;
  ctrl_t     ctrl;

  assign ready        = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign illegal_next = (TRAP_ILLEGAL != 0) ? ST_TRAP : ST_FETCH;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = ST_FETCH;
    case (state_reg)
      ST_FETCH:  state_next = ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_EXECUTE;
          OP_BEQ:       state_next = ST_BRANCH;
          OP_BNE:       state_next = (BNE_EN != 0) ? ST_BRANCH : illegal_next;
          OP_ADDI:      state_next = ST_ADDIEX;
          OP_J:         state_next = ST_JUMP;
          default:      state_next = illegal_next;
        endcase
      end
      ST_MEMADR:  state_next = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:   state_next = ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:   state_next = ST_FETCH;
      ST_MEMWR:   state_next = ready ? ST_FETCH : ST_MEMWR;
      ST_EXECUTE: state_next = ST_ALUWB;
      ST_ALUWB:   state_next = ST_FETCH;
      ST_BRANCH:  state_next = ST_FETCH;
      ST_ADDIEX:  state_next = ST_ADDIWB;
      ST_ADDIWB:  state_next = ST_FETCH;
      ST_JUMP:    state_next = ST_FETCH;
      ST_TRAP:    state_next = ST_TRAP;
      default:    state_next = ST_FETCH;
    endcase
  end

  mc_out_dec #(
    .BNE_EN(BNE_EN)
  ) u_out_dec (
    .state (state_reg),
    .op    (op),
    .ready (ready),
    .reset (reset),
    .ctrl  (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign iord       = ctrl.iord;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign branch     = ctrl.branch;
  assign branch_ne  = ctrl.branch_ne;
  assign pc_write   = ctrl.pc_write;
  assign trap       = ctrl.trap;

  generate
    if (ALUOP_W > 2) begin : g_aluop_wide
      assign alu_op = {{(ALUOP_W-2){1'b0}}, ctrl.alu_op};
    end else begin : g_aluop_narrow
      assign alu_op = ctrl.alu_op[ALUOP_W-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: three configurations, directed instruction
// sequences with literal expectations, then randomized traffic vs a model.
module tb_mc_control_fsm;

  localparam int ND = 3;
  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                         T_BEQ = 6'b000100, T_BNE = 6'b000101,
                         T_ADDI = 6'b001000, T_J = 6'b000010;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7,
                 S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11,
                 S_TRAP = 12;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic       branch_ne;
    logic       pc_write;
    logic       trap;
  } cw_t;

  logic       clk = 1'b0;
  logic       reset_s [ND];
  logic [5:0] op_s    [ND];
  logic       rdy_s   [ND];
  cw_t        act     [ND];

  int checks = 0;
  int errors = 0;
  int step [ND];
  int pend [ND][$];

  always #5 clk = ~clk;

  // dut 0: defaults; dut 1: BNE illegal, trapping; dut 2: no trap,
  // handshake ignored, 3-bit alu_op.
  function automatic int cfg_bne(int d);  return (d == 1) ? 0 : 1; endfunction
  function automatic int cfg_trap(int d); return (d == 2) ? 0 : 1; endfunction
  function automatic int cfg_hs(int d);   return (d == 2) ? 0 : 1; endfunction

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int AW = (gi == 2) ? 3 : 2;
    logic mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic alu_src_a, branch, branch_ne, pc_write, trap;
    logic [1:0] alu_src_b, pc_src;
    logic [AW-1:0] alu_op;

    mc_control_fsm #(
      .ALUOP_W      (AW),
      .MEM_HANDSHAKE(cfg_hs(gi)),
      .BNE_EN       (cfg_bne(gi)),
      .TRAP_ILLEGAL (cfg_trap(gi))
    ) dut (
      .clk       (clk),
      .reset     (reset_s[gi]),
      .op        (op_s[gi]),
      .mem_ready (rdy_s[gi]),
      .mem_req   (mem_req),
      .iord      (iord),
      .mem_write (mem_write),
      .ir_write  (ir_write),
      .reg_dst   (reg_dst),
      .mem_to_reg(mem_to_reg),
      .reg_write (reg_write),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .alu_op    (alu_op),
      .pc_src    (pc_src),
      .branch    (branch),
      .branch_ne (branch_ne),
      .pc_write  (pc_write),
      .trap      (trap)
    );

    assign act[gi] = {mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                      reg_write, alu_src_a, alu_src_b, 3'(alu_op), pc_src,
                      branch, branch_ne, pc_write, trap};
  end

  // Expected control word for one micro-step of an instruction.
  function automatic cw_t exp_cw(int s, logic rdy, logic rst, logic [5:0] o, int bne);
    cw_t w = '0;
    if (rst) begin
      w.alu_src_b = 2'b01;
      return w;
    end
    case (s)
      S_FETCH:  begin w.mem_req = 1; w.alu_src_b = 2'b01; w.ir_write = rdy; w.pc_write = rdy; end
      S_DECODE: w.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
      S_MEMRD:  begin w.mem_req = 1; w.iord = 1; end
      S_MEMWB:  begin w.reg_write = 1; w.mem_to_reg = 1; end
      S_MEMWR:  begin w.mem_req = 1; w.iord = 1; w.mem_write = rdy; end
      S_EXEC:   begin w.alu_src_a = 1; w.alu_op = 3'd2; end
      S_ALUWB:  begin w.reg_write = 1; w.reg_dst = 1; end
      S_BRANCH: begin
        w.alu_src_a = 1; w.alu_op = 3'd1; w.pc_src = 2'b01;
        w.branch = (o == T_BEQ); w.branch_ne = (bne != 0) && (o == T_BNE);
      end
      S_ADDIWB: w.reg_write = 1;
      S_JUMP:   begin w.pc_src = 2'b10; w.pc_write = 1; end
      S_TRAP:   w.trap = 1;
      default:  w = '0;
    endcase
    return w;
  endfunction

  // Model: after DECODE an instruction is a fixed list of steps chosen by op.
  task automatic model_advance(int d, logic rdy);
    if (reset_s[d]) begin
      step[d] = S_FETCH;
      pend[d].delete();
      return;
    end
    case (step[d])
      S_FETCH: if (rdy) step[d] = S_DECODE;
      S_DECODE: begin
        pend[d].delete();
        case (op_s[d])
          T_LW:   begin pend[d].push_back(S_MEMADR); pend[d].push_back(S_MEMRD); pend[d].push_back(S_MEMWB); end
          T_SW:   begin pend[d].push_back(S_MEMADR); pend[d].push_back(S_MEMWR); end
          T_R:    begin pend[d].push_back(S_EXEC); pend[d].push_back(S_ALUWB); end
          T_BEQ:  pend[d].push_back(S_BRANCH);
          T_ADDI: begin pend[d].push_back(S_ADDIEX); pend[d].push_back(S_ADDIWB); end
          T_J:    pend[d].push_back(S_JUMP);
          default: ;
        endcase
        if (op_s[d] == T_BNE && cfg_bne(d) != 0) pend[d].push_back(S_BRANCH);
        else if (pend[d].size() == 0 && cfg_trap(d) != 0) pend[d].push_back(S_TRAP);
        step[d] = (pend[d].size() != 0) ? pend[d].pop_front() : S_FETCH;
      end
      S_TRAP: ;
      default: begin
        if ((step[d] == S_MEMRD || step[d] == S_MEMWR) && !rdy) ;
        else step[d] = (pend[d].size() != 0) ? pend[d].pop_front() : S_FETCH;
      end
    endcase
  endtask

  // One clock: compare all DUTs against the model, advance, move to next negedge.
  task automatic cyc();
    #1;
    for (int d = 0; d < ND; d++) begin
      logic rdy;
      cw_t  e, a;
      rdy = (cfg_hs(d) != 0) ? rdy_s[d] : 1'b1;
      e = exp_cw(step[d], rdy, reset_s[d], op_s[d], cfg_bne(d));
      a = act[d];
      if (reset_s[d]) begin a.trap = 1'b0; e.trap = 1'b0; end
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cw dut%0d step%0d op=%b: got %05h want %05h", d, step[d], op_s[d], a, e);
      end
      model_advance(d, rdy);
    end
    @(negedge clk);
  endtask

  task automatic lit(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic park_all();
    for (int d = 0; d < ND; d++) begin
      reset_s[d] = 1'b1; op_s[d] = 6'd0; rdy_s[d] = 1'b1;
    end
  endtask

  task automatic drive(int d, logic [5:0] o, logic r);
    reset_s[d] = 1'b0; op_s[d] = o; rdy_s[d] = r;
  endtask

  initial begin
    park_all();
    for (int d = 0; d < ND; d++) step[d] = S_FETCH;
    @(negedge clk);
    cyc();
    #1;
    lit("reset_mem_req", act[0].mem_req, 0);
    lit("reset_alu_src_b", act[0].alu_src_b, 1);
    lit("reset_trap", act[0].trap, 0);
    cyc();

    // LW, memory always ready: 5 cycles.
    drive(0, T_LW, 1'b1); #1;
    lit("lw_c1_ir_write", act[0].ir_write, 1);
    lit("lw_c1_pc_write", act[0].pc_write, 1);
    cyc(); #1;
    lit("lw_c2_alu_src_b", act[0].alu_src_b, 3);
    lit("lw_c2_ir_write", act[0].ir_write, 0);
    cyc(); #1;
    lit("lw_c3_reg_write", act[0].reg_write, 0);
    cyc(); #1;
    lit("lw_c4_iord", act[0].iord, 1);
    cyc(); #1;
    lit("lw_c5_reg_write", act[0].reg_write, 1);
    lit("lw_c5_mem_to_reg", act[0].mem_to_reg, 1);
    cyc();

    // SW with two wait cycles in MEMWR.
    drive(0, T_SW, 1'b1); #1;
    lit("sw_c1_ir_write", act[0].ir_write, 1);
    cyc(); cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      rdy_s[0] = (i == 2); #1;
      lit("sw_memwr_mem_req", act[0].mem_req, 1);
      lit("sw_memwr_mem_write", act[0].mem_write, (i == 2) ? 1 : 0);
      lit("sw_memwr_reg_write", act[0].reg_write, 0);
      cyc();
    end

    // R-type.
    drive(0, T_R, 1'b1); cyc(); cyc(); #1;
    lit("r_exec_alu_op", act[0].alu_op, 2);
    lit("r_exec_alu_src_b", act[0].alu_src_b, 0);
    cyc(); #1;
    lit("r_wb_reg_dst", act[0].reg_dst, 1);
    lit("r_wb_reg_write", act[0].reg_write, 1);
    cyc(); #1;
    lit("r_c5_fetch_ir_write", act[0].ir_write, 1);

    // BEQ then BNE.
    drive(0, T_BEQ, 1'b1); cyc(); cyc(); #1;
    lit("beq_branch", act[0].branch, 1);
    lit("beq_branch_ne", act[0].branch_ne, 0);
    lit("beq_pc_src", act[0].pc_src, 1);
    cyc();
    drive(0, T_BNE, 1'b1); cyc(); cyc(); #1;
    lit("bne_branch", act[0].branch, 0);
    lit("bne_branch_ne", act[0].branch_ne, 1);
    cyc();

    // Reset while LW waits in MEMRD.
    drive(0, T_LW, 1'b1); cyc(); cyc(); cyc();
    rdy_s[0] = 1'b0; reset_s[0] = 1'b1; #1;
    lit("rst_memrd_mem_req", act[0].mem_req, 0);
    lit("rst_memrd_iord", act[0].iord, 0);
    cyc();
    drive(0, T_LW, 1'b0); #1;
    lit("rst_after_fetch_mem_req", act[0].mem_req, 1);
    lit("rst_after_fetch_iord", act[0].iord, 0);
    lit("rst_after_trap", act[0].trap, 0);
    cyc();

    // BNE with BNE disabled traps until reset.
    park_all(); cyc();
    drive(1, T_BNE, 1'b1); cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      #1; lit("bne_off_trap", act[1].trap, 1);
      lit("bne_off_branch_ne", act[1].branch_ne, 0);
      cyc();
    end
    reset_s[1] = 1'b1; cyc();
    reset_s[1] = 1'b0; #1;
    lit("bne_off_trap_cleared", act[1].trap, 0);
    cyc();

    // Illegal op without trapping returns to FETCH.
    park_all(); cyc();
    drive(2, 6'b111111, 1'b0); cyc(); #1;
    lit("ill_decode_reg_write", act[2].reg_write, 0);
    cyc(); #1;
    lit("ill_back_fetch_ir_write", act[2].ir_write, 1);
    lit("ill_trap", act[2].trap, 0);
    cyc();

    // Randomized traffic on all three configurations.
    park_all(); cyc();
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < ND; d++) begin
        reset_s[d] = ($urandom_range(0, 59) == 0) ||
                     (step[d] == S_TRAP && $urandom_range(0, 3) == 0);
        rdy_s[d] = ($urandom_range(0, 2) != 0);
        if (step[d] == S_FETCH) begin
          case ($urandom_range(0, 8))
            0: op_s[d] = T_R;    1: op_s[d] = T_LW;  2: op_s[d] = T_SW;
            3: op_s[d] = T_BEQ;  4: op_s[d] = T_BNE; 5: op_s[d] = T_ADDI;
            6: op_s[d] = T_J;    7: op_s[d] = T_LW;
            default: op_s[d] = 6'($urandom);
          endcase
        end
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multicycle successor to the single-cycle main decoder.
- A Moore control FSM that sequences each MIPS instruction through fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory ready/request handshake, optional BNE support, and illegal-opcode trapping.
- Sits between the instruction register opcode field and the multicycle datapath (PC, IR, register file, ALU muxes, unified memory).

Parameters:
- ALUOP_W, 2, width of alu_op; codes 00 add, 01 sub, 10 funct-decoded; upper bits zero when wider.
- MEM_HANDSHAKE, 1, 1 means mem_ready gates memory states; 0 means mem_ready is ignored and treated as 1.
- BNE_EN, 1, 1 means opcode 000101 (BNE) is legal.
- TRAP_ILLEGAL, 1, 1 means an illegal opcode enters TRAP; 0 means it returns to FETCH as a no-op.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  opcode from instruction register (IR[31:26]).
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access requested.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = memory data, 0 = ALUOut.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A register.
- alu_src_b  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2.
- alu_op  out  ALUOP_W  ALU operation class.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- branch  out  1  branch-if-equal enable.
- branch_ne  out  1  branch-if-not-equal enable.
- pc_write  out  1  unconditional PC load.
- trap  out  1  sticky illegal-opcode flag.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state:
  - While reset is high, the state register loads FETCH at the edge and trap clears.
  - All strobes (mem_req, mem_write, ir_write, reg_write, pc_write, branch, branch_ne) are forced 0 combinationally while reset is high.
  - Mux selects output the FETCH values during reset.
- Outputs are pure functions of the state, except the strobes gated by mem_ready. Unlisted outputs are 0.
- States and per-state outputs:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00; ir_write=pc_write=mem_ready. Next state is DECODE if mem_ready, else stays in FETCH.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=add.
    - Next state by op: LW 100011 or SW 101011 go to MEMADR; R-type 000000 goes to EXECUTE; BEQ 000100 goes to BRANCH; BNE 000101 goes to BRANCH if BNE_EN, else it is illegal.
    - ADDI 001000 goes to ADDIEX; J 000010 goes to JUMP.
    - Any other op goes to TRAP if TRAP_ILLEGAL, else to FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add. Next state is MEMRD for LW, MEMWR for SW.
  - MEMRD: mem_req=1, iord=1. Next state is MEMWB if mem_ready, else stays in MEMRD.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state is FETCH.
  - MEMWR: mem_req=1, iord=1, mem_write=mem_ready. Next state is FETCH if mem_ready, else stays in MEMWR.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01; branch=1 if the latched op is BEQ, branch_ne=1 if BNE. Next state is FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=add. Next state is ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
  - JUMP: pc_src=10, pc_write=1. Next state is FETCH.
  - TRAP: trap=1 and all strobes 0. The FSM stays in TRAP until reset.
- op usage: op is sampled in DECODE, MEMADR and BRANCH. The datapath holds IR stable from DECODE through instruction end, so the FSM does not latch op.
- Latency in cycles, with memory ready on the first cycle: R-type 4, ADDI 4, BEQ/BNE 3, J 3, SW 4, LW 5. Each memory wait adds 1.
- Memory handshake: mem_req is held until the cycle mem_ready=1. A mem_ready pulse in a non-memory state is ignored.
- Mid-instruction reset: reset aborts any state, including a pending memory wait; no strobe is issued in the reset cycle.
- Encoding: the state is a package enum, 4 bits minimum. An unreachable encoding recovers to FETCH on the next edge.

Decomposition:
- Package mips_ctrl_pkg holds: the state enum mc_state_t, opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J), and alu_op codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT).
- One natural sub-module: mc_out_dec, the combinational state-to-control-word decode plus mem_ready gating. Next-state logic and the state register stay in the top module.

Test Plan:
- LW, mem_ready tied 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_write=1, mem_to_reg=1 only in cycle 5; ir_write and pc_write only in cycle 1.
- SW with mem_ready low for 2 cycles in MEMWR → mem_req=1 for 3 cycles; mem_write=1 only in the third; no reg_write throughout.
- R-type 000000 → EXECUTE drives alu_op=10, alu_src_b=00; ALUWB drives reg_dst=1, reg_write=1; back in FETCH at cycle 5.
- BEQ, then BNE with BNE_EN=1 → branch=1, branch_ne=0, then branch=0, branch_ne=1, each in cycle 3 with pc_src=01. Repeat BNE with BNE_EN=0 and TRAP_ILLEGAL=1 → trap=1, held until reset.
- Illegal op 111111 with TRAP_ILLEGAL=0 → returns to FETCH after DECODE; trap stays 0; no write strobe asserted.
- Reset asserted in MEMRD with mem_ready low → the next cycle is FETCH; during the reset cycle all strobes are 0; trap=0.
